// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port and the data port of the pipeline.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-low reset
//   if_req/if_addr              fetch request, held until if_ready
//   if_rdata/if_ready           fetched word and one-cycle completion pulse
//   d_req/d_we/d_be/d_addr/d_wdata  data request fields, held until d_ready
//   d_rdata/d_ready             load data and one-cycle completion pulse
//   stall_f/stall_m             combinational stall flags for the hazard unit
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_ack/mem_rdata           memory completion and read data
//   bus_err                     sticky timeout flag, cleared only by reset
module mem_port_arbiter #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            stall_f,
  output logic            stall_m,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            bus_err
);

  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned SW = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] streak;
  logic          data_win_c;

  // Stall flags track the live request against this cycle's completion pulse.
  assign stall_f = if_req & ~if_ready;
  assign stall_m = d_req & ~d_ready;

  // Data wins a contested IDLE cycle unless it has already starved fetch for
  // MAX_DATA_BURST consecutive grants.
  assign data_win_c = d_req & (~if_req | (streak != SW'(MAX_DATA_BURST)));

  // Arbiter FSM with registered memory handshake and port responses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      streak    <= '0;
      if_rdata  <= '0;
      if_ready  <= 1'b0;
      d_rdata   <= '0;
      d_ready   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (data_win_c) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Only grants that keep a pending fetch waiting count toward the streak.
            if (if_req) streak <= streak + 1'b1;
            else        streak <= '0;
          end else if (if_req) begin
            state     <= FETCH;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= '1;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak    <= '0;
          end else begin
            streak <= '0;
          end
        end

        FETCH, DATA: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (state == FETCH) begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              d_ready <= 1'b1;
              d_rdata <= mem_we ? '0 : mem_rdata;
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            // Abort: still complete the port so the pipeline never deadlocks.
            state   <= RESP;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (state == FETCH) begin
              if_ready <= 1'b1;
              if_rdata <= '0;
            end else begin
              d_ready <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transfers plus hand-written
// contention, burst-limit and mid-transfer reset sequences. Expected read data
// is queued per port when a request is driven and compared on each ready pulse.
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned TMO   = 8;
  localparam int unsigned BURST = 4;
  localparam logic [7:0]  GD    = 8'h44;  // 'D'
  localparam logic [7:0]  GF    = 8'h46;  // 'F'

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          stall_f;
  logic          stall_m;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          bus_err;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_DATA_BURST(BURST), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Memory contents as seen by the bench.
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: acks after lat_r waiting cycles when enabled.
  logic ack_en    = 1'b0;
  logic ack_force = 1'b0;
  int   lat_r     = 0;
  int   wcnt      = 0;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  assign mem_ack   = ack_force | (mem_req & ack_en & (wcnt >= lat_r));
  assign mem_rdata = model_rd(mem_addr);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues and held-value trackers.
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] if_hold = '0;
  logic [31:0] d_hold  = '0;
  logic [7:0]  glog[$];
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (if_ready && d_ready) chk("both_ready", 32'(if_ready & d_ready), 32'd0);
      if (if_ready) begin
        if (if_q.size() == 0) chk("unexpected_if_ready", 32'(if_ready), 32'd0);
        else if_hold = if_q.pop_front();
      end
      if (d_ready) begin
        if (d_q.size() == 0) chk("unexpected_d_ready", 32'(d_ready), 32'd0);
        else d_hold = d_q.pop_front();
      end
      chk("if_rdata", if_rdata, if_hold);
      chk("d_rdata", d_rdata, d_hold);
      chk("stall_f", 32'(stall_f), 32'(if_req & ~if_ready));
      chk("stall_m", 32'(stall_m), 32'(d_req & ~d_ready));
      if (mem_req && mem_ack) glog.push_back(mem_addr[28] ? GF : GD);
    end
  end

  typedef struct {
    bit          is_data;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;        // -1: memory never acks
    logic [31:0] exp_rdata;
    int          exp_cyc;    // cycles from driving req to ready pulse
    bit          exp_err;
  } vec_t;

  vec_t vt[10];

  // One isolated transfer: checks latched memory fields, latency and bus_err.
  task automatic run_vec(input vec_t v, input int idx);
    int  cyc;
    bit  done;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    lat_r  = (v.lat < 0) ? 0 : v.lat;
    ack_en = (v.lat >= 0);
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
      d_q.push_back(v.exp_rdata);
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      if_q.push_back(v.exp_rdata);
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, v.addr);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(v.we));
        chk({tag, "_mem_be"}, 32'(mem_be), 32'(v.be));
        if (v.is_data && v.we) chk({tag, "_mem_wdata"}, mem_wdata, v.wdata);
      end
      done = v.is_data ? d_ready : if_ready;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(v.exp_cyc));
    chk({tag, "_mem_req_off"}, 32'(mem_req), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'(v.exp_err));
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  // Streams of back-to-back requests with req held across completions.
  task automatic fetch_stream(input int n, input logic [31:0] base);
    if_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      int k;
      if_addr = base + 32'(4 * i);
      if_q.push_back(model_rd(if_addr));
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!if_ready && k < 60);
      chk("fetch_stream_ready", 32'(if_ready), 32'd1);
    end
    if_req = 1'b0;
  endtask

  task automatic data_stream(input int n, input logic [31:0] base);
    d_we = 1'b0; d_be = 4'hF; d_wdata = '0; d_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      int k;
      d_addr = base + 32'(4 * i);
      d_q.push_back(model_rd(d_addr));
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!d_ready && k < 60);
      chk("data_stream_ready", 32'(d_ready), 32'd1);
    end
    d_req = 1'b0;
  endtask

  task automatic chk_glog(input string name, input string exp);
    chk({name, "_count"}, 32'(glog.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len() && i < glog.size(); i++)
      chk($sformatf("%s_grant%0d", name, i), 32'(glog[i]), 32'(exp[i]));
  endtask

  initial begin
    vec_t rec;
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;

    vt[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 0, 32'h0050_0093, 2, 1'b0};
    vt[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 0, model_rd(32'h2000), 2, 1'b0};
    vt[2] = '{1'b1, 1'b1, 4'b0011, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0, 2, 1'b0};
    vt[3] = '{1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 2, model_rd(32'h104), 4, 1'b0};
    vt[4] = '{1'b1, 1'b0, 4'hF, 32'h0000_2004, 32'h0, 3, model_rd(32'h2004), 5, 1'b0};
    vt[5] = '{1'b1, 1'b1, 4'b1100, 32'h0000_0044, 32'h1234_5678, 1, 32'h0, 3, 1'b0};
    vt[6] = '{1'b1, 1'b0, 4'hF, 32'h0000_2008, 32'h0, -1, 32'h0, 9, 1'b1};
    vt[7] = '{1'b1, 1'b0, 4'hF, 32'h0000_200C, 32'h0, 0, model_rd(32'h200C), 2, 1'b1};
    vt[8] = '{1'b0, 1'b0, 4'hF, 32'h0000_0108, 32'h0, -1, 32'h0, 9, 1'b1};
    vt[9] = '{1'b0, 1'b0, 4'hF, 32'h0000_010C, 32'h0, 1, model_rd(32'h10C), 3, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Isolated transfers, including timeouts and sticky bus_err.
    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Simultaneous fetch and load: data first, then fetch.
    @(posedge clk); #1;
    ack_en = 1'b1; lat_r = 0;
    glog.delete();
    fork
      fetch_stream(1, 32'h1000_0300);
      data_stream(1, 32'h0000_2000);
    join
    chk_glog("contend", "DF");

    // Both held: fetch breaks in after MAX_DATA_BURST data grants.
    @(posedge clk); #1;
    glog.delete();
    fork
      fetch_stream(2, 32'h1000_0400);
      data_stream(6, 32'h0000_3000);
    join
    chk_glog("burst", "DDDDFDDF");
    chk("bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset during FETCH; a late ack afterwards must be ignored.
    @(posedge clk); #1;
    ack_en = 1'b0;
    if_req = 1'b1; if_addr = 32'h1000_0500;
    @(posedge clk); #1;
    chk("mid_fetch_mem_req", 32'(mem_req), 32'd1);
    chk("mid_fetch_addr", mem_addr, 32'h1000_0500);
    reset = 1'b0;
    @(posedge clk); #1;
    if_hold = '0;
    d_hold  = '0;
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_if_ready", 32'(if_ready), 32'd0);
    chk("mid_rst_bus_err", 32'(bus_err), 32'd0);
    if_req    = 1'b0;
    reset     = 1'b1;
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_if_ready", 32'(if_ready), 32'd0);
      chk("post_rst_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
    end

    // Normal operation after reset.
    rec = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 0, 32'h0050_0093, 2, 1'b0};
    run_vec(rec, 10);
    repeat (2) @(posedge clk);
    #1;
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("d_q_drained", 32'(d_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
